// File: rtl/spi_pkg.sv
// Shared types and constants for the 16-bit SPI master.
// Select codes map the 3-bit ss field onto the five slave-select lines.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FRONT,
    SHIFT,
    BACK
  } spi_state_t;

  localparam logic [2:0] SS_AFE1 = 3'd0;
  localparam logic [2:0] SS_AFE2 = 3'd1;
  localparam logic [2:0] SS_AFE3 = 3'd2;
  localparam logic [2:0] SS_TRIG = 3'd3;
  localparam logic [2:0] SS_EEP  = 3'd4;
  localparam logic [2:0] SS_NONE = 3'd7;

  localparam int SPI_WORD_W = 16;

  function automatic logic [4:0] ss_decode(
    input logic [2:0] sel
  );
    logic [4:0] m;
    m = 5'h1F;
    unique case (1'b1)
      (sel == SS_AFE1): m = 5'b11110;
      (sel == SS_AFE2): m = 5'b11101;
      (sel == SS_AFE3): m = 5'b11011;
      (sel == SS_TRIG): m = 5'b10111;
      (sel == SS_EEP):  m = 5'b01111;
      (sel == SS_NONE): m = 5'h1F;
      default:          m = 5'h1F;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: divides clk by SCLK_DIV while enabled, idle low.
// Rise strobe fires the cycle before SCLK goes high; fall on the wrap.
module spi_sclk_gen #(
  parameter int SCLK_DIV = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(SCLK_DIV);
  localparam logic [CW-1:0] C_HALF = CW'(SCLK_DIV / 2);
  localparam logic [CW-1:0] C_RISE = CW'(SCLK_DIV / 2 - 1);
  localparam logic [CW-1:0] C_LAST = CW'(SCLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sclk = i_en && (r_cnt >= C_HALF);
  assign o_rise = i_en && (r_cnt == C_RISE);
  assign o_fall = i_en && (r_cnt == C_LAST);

endmodule

// File: rtl/spi_mstr16.sv
// 16-bit mode-0 SPI master with five decoded slave selects.
// Optional macro SPI_MISO_SYNC_EN adds a 2-flop MISO synchronizer.
module spi_mstr16
  import spi_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wrt_SPI,
  input  logic [SPI_WORD_W-1:0] SPI_data,
  input  logic [2:0]            ss,
  input  logic                  MISO,
  output logic                  SCLK,
  output logic                  MOSI,
  output logic [4:0]            SS_n,
  output logic                  busy,
  output logic                  SPI_done,
  output logic [SPI_WORD_W-1:0] rd_data,
  output logic [7:0]            EEP_data
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int CW   = $clog2(SCLK_DIV);
  localparam logic [CW-1:0] P_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] P_LOAD = CW'(HALF - 2);

  spi_state_t r_state;
  spi_state_t w_nxt;

  logic [CW-1:0]         r_pcnt;
  logic [4:0]            r_bit_cnt;
  logic [SPI_WORD_W-1:0] r_tx;
  logic [SPI_WORD_W-1:0] r_rx;
  logic [SPI_WORD_W-1:0] r_rd;
  logic [4:0]            r_ssq;
  logic                  r_done;

  logic w_sclk;
  logic w_rise;
  logic w_fall;
  logic w_smp;
  logic w_miso;

  spi_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_state == SHIFT),
    .o_sclk (w_sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] r_miso_s;
  logic [1:0] r_rise_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miso_s <= '0;
      r_rise_d <= '0;
    end else begin
      r_miso_s <= {r_miso_s[0], MISO};
      r_rise_d <= {r_rise_d[0], w_rise};
    end
  end

  assign w_miso = r_miso_s[1];
  assign w_smp  = r_rise_d[1];
`else
  assign w_miso = MISO;
  assign w_smp  = w_rise;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:  if (wrt_SPI) w_nxt = FRONT;
      FRONT: if (r_pcnt == P_LAST) w_nxt = SHIFT;
      SHIFT: begin
        if (w_fall && (r_bit_cnt + 5'd1) == 5'd16)
          w_nxt = BACK;
      end
      BACK:  if (r_pcnt == P_LAST) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt    <= '0;
      r_bit_cnt <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rd      <= '0;
      r_ssq     <= 5'h1F;
      r_done    <= 1'b0;
    end else begin
      // done/rd_data land together so rd_data is valid on the pulse
      r_done <= (r_state == BACK) && (r_pcnt == P_LOAD);
      if (w_nxt != r_state)
        r_pcnt <= '0;
      else if (r_state == FRONT || r_state == BACK)
        r_pcnt <= r_pcnt + 1'b1;
      if (r_state == IDLE && wrt_SPI) begin
        r_tx      <= SPI_data;
        r_ssq     <= ss_decode(ss);
        r_bit_cnt <= '0;
        r_rx      <= '0;
      end
      if (r_state == SHIFT) begin
        if (w_smp)
          r_rx <= {r_rx[SPI_WORD_W-2:0], w_miso};
        if (w_fall) begin
          r_tx      <= {r_tx[SPI_WORD_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
      end
      if (r_state == BACK && r_pcnt == P_LOAD)
        r_rd <= r_rx;
    end
  end

  assign SCLK     = w_sclk;
  assign MOSI     = r_tx[SPI_WORD_W-1];
  assign busy     = (r_state != IDLE);
  assign SS_n     = busy ? r_ssq : 5'h1F;
  assign SPI_done = r_done;
  assign rd_data  = r_rd;
  assign EEP_data = r_rd[7:0];

endmodule
